// File: rtl/tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings and default instruction opcodes.
package tap_pkg;

    typedef enum logic [3:0] {
        ST_EX2_DR  = 4'h0,
        ST_EX1_DR  = 4'h1,
        ST_SH_DR   = 4'h2,
        ST_PAU_DR  = 4'h3,
        ST_SEL_IR  = 4'h4,
        ST_UPD_DR  = 4'h5,
        ST_CAP_DR  = 4'h6,
        ST_SEL_DR  = 4'h7,
        ST_EX2_IR  = 4'h8,
        ST_EX1_IR  = 4'h9,
        ST_SH_IR   = 4'hA,
        ST_PAU_IR  = 4'hB,
        ST_RTI     = 4'hC,
        ST_UPD_IR  = 4'hD,
        ST_CAP_IR  = 4'hE,
        ST_TLR     = 4'hF
    } tap_state_t;

    localparam logic [3:0] DEF_OP_EXTEST = 4'b0000;
    localparam logic [3:0] DEF_OP_SAMPLE = 4'b0001;
    localparam logic [3:0] DEF_OP_IDCODE = 4'b0010;
    localparam logic [3:0] DEF_OP_BYPASS = 4'b1111;

    function automatic logic in_ir_column(input tap_state_t s);
        return (s == ST_CAP_IR) || (s == ST_SH_IR) || (s == ST_EX1_IR) ||
               (s == ST_PAU_IR) || (s == ST_EX2_IR) || (s == ST_UPD_IR);
    endfunction

endpackage

// File: rtl/tap_ir.sv
// Instruction register: capture/shift register, latched instruction and
// one-hot data-register select decode.
module tap_ir
    import tap_pkg::*;
#(
    parameter int unsigned          IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0]  OP_EXTEST = IR_WIDTH'(DEF_OP_EXTEST),
    parameter logic [IR_WIDTH-1:0]  OP_SAMPLE = IR_WIDTH'(DEF_OP_SAMPLE),
    parameter logic [IR_WIDTH-1:0]  OP_IDCODE = IR_WIDTH'(DEF_OP_IDCODE)
) (
    input  logic       clk,
    input  logic       rst,
    input  tap_state_t state,
    input  logic       to_tlr,
    input  logic       tdi,
    output logic       tdo_ir,
    output logic       sel_bypass,
    output logic       sel_idcode,
    output logic       sel_bsr,
    output logic       bs_mode
);

    logic [IR_WIDTH-1:0] shift_reg;
    logic [IR_WIDTH-1:0] latched;

    // Entering Test-Logic-Reset via TMS restores IDCODE just as RST does;
    // the shift register is left alone so only the instruction is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            latched   <= OP_IDCODE;
        end else begin
            case (state)
                ST_CAP_IR: shift_reg <= IR_WIDTH'(2'b01);
                ST_SH_IR:  shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
                default:   shift_reg <= shift_reg;
            endcase
            if (to_tlr)
                latched <= OP_IDCODE;
            else if (state == ST_UPD_IR)
                latched <= shift_reg;
        end
    end

    assign tdo_ir = shift_reg[0];

    always_comb begin
        sel_bypass = 1'b0;
        sel_idcode = 1'b0;
        sel_bsr    = 1'b0;
        bs_mode    = 1'b0;
        if (latched == OP_EXTEST) begin
            sel_bsr = 1'b1;
            bs_mode = 1'b1;
        end else if (latched == OP_SAMPLE) begin
            sel_bsr = 1'b1;
        end else if (latched == OP_IDCODE) begin
            sel_idcode = 1'b1;
        end else begin
            sel_bypass = 1'b1;
        end
    end

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: 16-state TMS-driven FSM, scan strobes and TDO path
// select, with the instruction register in tap_ir.
module tap_controller
    import tap_pkg::*;
#(
    parameter int unsigned          IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0]  OP_EXTEST = IR_WIDTH'(DEF_OP_EXTEST),
    parameter logic [IR_WIDTH-1:0]  OP_SAMPLE = IR_WIDTH'(DEF_OP_SAMPLE),
    parameter logic [IR_WIDTH-1:0]  OP_IDCODE = IR_WIDTH'(DEF_OP_IDCODE),
    parameter logic [IR_WIDTH-1:0]  OP_BYPASS = IR_WIDTH'(DEF_OP_BYPASS)
) (
    input  logic       TCK,
    input  logic       RST,
    input  logic       TMS,
    input  logic       TDI,
    output logic       Sel_MUX,
    output logic       TDO_EN,
    output logic       TDO_IR,
    output logic       Capture_DR,
    output logic       Shift_DR,
    output logic       Update_DR,
    output logic       Sel_Bypass,
    output logic       Sel_IDCODE,
    output logic       Sel_BSR,
    output logic       BS_Mode,
    output logic [3:0] Tap_State
);

    tap_state_t state, next_state;

    always_ff @(posedge TCK) begin
        if (RST)
            state <= ST_TLR;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = ST_TLR;
        unique case (state)
            ST_TLR:    next_state = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    next_state = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: next_state = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_SEL_IR: next_state = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_DR: next_state = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  next_state = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: next_state = TMS ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: next_state = TMS ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: next_state = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: next_state = TMS ? ST_SEL_DR : ST_RTI;
            ST_CAP_IR: next_state = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  next_state = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: next_state = TMS ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: next_state = TMS ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: next_state = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: next_state = TMS ? ST_SEL_DR : ST_RTI;
            default:   next_state = ST_TLR;
        endcase
    end

    always_comb begin
        Sel_MUX    = in_ir_column(state);
        TDO_EN     = (state == ST_SH_IR) || (state == ST_SH_DR);
        Capture_DR = (state == ST_CAP_DR);
        Shift_DR   = (state == ST_SH_DR);
        Update_DR  = (state == ST_UPD_DR);
        Tap_State  = state;
    end

    // OP_BYPASS needs no explicit decode: every unmatched opcode selects bypass.
    tap_ir #(
        .IR_WIDTH  (IR_WIDTH),
        .OP_EXTEST (OP_EXTEST),
        .OP_SAMPLE (OP_SAMPLE),
        .OP_IDCODE (OP_IDCODE)
    ) u_ir (
        .clk        (TCK),
        .rst        (RST),
        .state      (state),
        .to_tlr     (next_state == ST_TLR),
        .tdi        (TDI),
        .tdo_ir     (TDO_IR),
        .sel_bypass (Sel_Bypass),
        .sel_idcode (Sel_IDCODE),
        .sel_bsr    (Sel_BSR),
        .bs_mode    (BS_Mode)
    );

endmodule

// File: tb/tb_tap_controller.sv
// Directed testbench for tap_controller: FSM walk, IR scans, DR scan strobes,
// TMS and RST reset paths.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       RST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       Sel_MUX, TDO_EN, TDO_IR, Capture_DR, Shift_DR, Update_DR;
    logic       Sel_Bypass, Sel_IDCODE, Sel_BSR, BS_Mode;
    logic [3:0] Tap_State;

    int checks = 0;
    int errors = 0;

    // {Sel_Bypass, Sel_IDCODE, Sel_BSR, BS_Mode}
    logic [3:0] sel;
    // {Sel_MUX, TDO_EN, Capture_DR, Shift_DR, Update_DR}
    logic [4:0] strobes;
    assign sel     = {Sel_Bypass, Sel_IDCODE, Sel_BSR, BS_Mode};
    assign strobes = {Sel_MUX, TDO_EN, Capture_DR, Shift_DR, Update_DR};

    tap_controller dut (
        .TCK        (TCK),
        .RST        (RST),
        .TMS        (TMS),
        .TDI        (TDI),
        .Sel_MUX    (Sel_MUX),
        .TDO_EN     (TDO_EN),
        .TDO_IR     (TDO_IR),
        .Capture_DR (Capture_DR),
        .Shift_DR   (Shift_DR),
        .Update_DR  (Update_DR),
        .Sel_Bypass (Sel_Bypass),
        .Sel_IDCODE (Sel_IDCODE),
        .Sel_BSR    (Sel_BSR),
        .BS_Mode    (BS_Mode),
        .Tap_State  (Tap_State)
    );

    always #5 TCK = ~TCK;

    task automatic tick(input logic tms_v, input logic tdi_v);
        TMS = tms_v;
        TDI = tdi_v;
        @(posedge TCK);
        #1;
    endtask

    // From RTI: load op (LSB first) and return to RTI.
    task automatic scan_ir(input logic [3:0] op);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            tick(i == 3, op[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        RST = 1'b0;
        checks++;
        if (Tap_State !== 4'hF || sel !== 4'b0100 || strobes !== 5'b0 || TDO_IR !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: state=%h sel=%b strobes=%b tdo_ir=%b, required F 0100 00000 0",
                     Tap_State, sel, strobes, TDO_IR);
        end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (Tap_State !== 4'h2) begin
            errors++;
            $display("FAIL reset_reach_shdr: state=%h, required 2", Tap_State);
        end
        RST = 1'b1;
        tick(1'b0, 1'b0);
        RST = 1'b0;
        checks++;
        if (Tap_State !== 4'hF || sel !== 4'b0100 || TDO_EN !== 1'b0) begin
            errors++;
            $display("FAIL reset_from_shdr: state=%h sel=%b tdo_en=%b, required F 0100 0",
                     Tap_State, sel, TDO_EN);
        end
    endtask

    task automatic test_fsm_walk();
        logic       tms_seq [22] = '{0,1,0,0,1,0,1,0,1,1,1,1,0,1,0,1,1,1,1,1,1,0};
        logic [3:0] exp_seq [22] = '{4'hC,4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h2,4'h1,4'h5,4'h7,
                                     4'h4,4'hE,4'h9,4'hB,4'h8,4'hD,4'h7,4'h4,4'hF,4'hF,4'hC};
        for (int i = 0; i < 22; i++) begin
            tick(tms_seq[i], 1'b0);
            checks++;
            if (Tap_State !== exp_seq[i]) begin
                errors++;
                $display("FAIL fsm_walk[%0d]: state=%h, required %h", i, Tap_State, exp_seq[i]);
            end
        end
    endtask

    task automatic test_ir_extest();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (Tap_State !== 4'hE || strobes !== 5'b10000) begin
            errors++;
            $display("FAIL extest_capir: state=%h strobes=%b, required E 10000", Tap_State, strobes);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (Tap_State !== 4'hA || strobes !== 5'b11000 || TDO_IR !== 1'b1) begin
            errors++;
            $display("FAIL extest_shir_bit0: state=%h strobes=%b tdo_ir=%b, required A 11000 1",
                     Tap_State, strobes, TDO_IR);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (TDO_IR !== 1'b0) begin
            errors++;
            $display("FAIL extest_shir_bit1: tdo_ir=%b, required 0", TDO_IR);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (Tap_State !== 4'h9 || sel !== 4'b0100) begin
            errors++;
            $display("FAIL extest_ex1ir: state=%h sel=%b, required 9 0100", Tap_State, sel);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (Tap_State !== 4'hD || sel !== 4'b0100) begin
            errors++;
            $display("FAIL extest_updir_hold: state=%h sel=%b, required D 0100", Tap_State, sel);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (Tap_State !== 4'hC || sel !== 4'b0011) begin
            errors++;
            $display("FAIL extest_latched: state=%h sel=%b, required C 0011", Tap_State, sel);
        end
    endtask

    task automatic test_tms_reset_pause_ir();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        checks++;
        if (Tap_State !== 4'hB) begin
            errors++;
            $display("FAIL tms5_reach_pauseir: state=%h, required B", Tap_State);
        end
        for (int i = 0; i < 5; i++)
            tick(1'b1, 1'b0);
        checks++;
        if (Tap_State !== 4'hF || sel !== 4'b0100) begin
            errors++;
            $display("FAIL tms5_from_pauseir: state=%h sel=%b, required F 0100", Tap_State, sel);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_bypass_undefined();
        scan_ir(4'b1010);
        checks++;
        if (Tap_State !== 4'hC || sel !== 4'b1000) begin
            errors++;
            $display("FAIL undefined_op_bypass: state=%h sel=%b, required C 1000", Tap_State, sel);
        end
    endtask

    task automatic test_tms_reset_shift_dr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (Tap_State !== 4'h2 || sel !== 4'b1000) begin
            errors++;
            $display("FAIL tms5_reach_shdr: state=%h sel=%b, required 2 1000", Tap_State, sel);
        end
        for (int i = 0; i < 5; i++)
            tick(1'b1, 1'b0);
        checks++;
        if (Tap_State !== 4'hF || sel !== 4'b0100) begin
            errors++;
            $display("FAIL tms5_from_shdr: state=%h sel=%b, required F 0100", Tap_State, sel);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_sample_idcode();
        scan_ir(4'b0001);
        checks++;
        if (sel !== 4'b0010) begin
            errors++;
            $display("FAIL sample_decode: sel=%b, required 0010", sel);
        end
        scan_ir(4'b0010);
        checks++;
        if (sel !== 4'b0100) begin
            errors++;
            $display("FAIL idcode_decode: sel=%b, required 0100", sel);
        end
        scan_ir(4'b0000);
    endtask

    task automatic test_dr_scan();
        logic       tms_seq [8] = '{1,0,0,0,0,1,1,0};
        logic [3:0] st_seq  [8] = '{4'h7,4'h6,4'h2,4'h2,4'h2,4'h1,4'h5,4'hC};
        logic [4:0] str_seq [8] = '{5'b00000,5'b00100,5'b01010,5'b01010,5'b01010,
                                    5'b00000,5'b00001,5'b00000};
        for (int i = 0; i < 8; i++) begin
            tick(tms_seq[i], 1'b1);
            checks++;
            if (Tap_State !== st_seq[i] || strobes !== str_seq[i] || sel !== 4'b0011) begin
                errors++;
                $display("FAIL dr_scan[%0d]: state=%h strobes=%b sel=%b, required %h %b 0011",
                         i, Tap_State, strobes, sel, st_seq[i], str_seq[i]);
            end
        end
    endtask

    task automatic test_rst_mid_shift();
        scan_ir(4'b1111);
        checks++;
        if (sel !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_bypass_set: sel=%b, required 1000", sel);
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        RST = 1'b1;
        tick(1'b0, 1'b0);
        RST = 1'b0;
        checks++;
        if (Tap_State !== 4'hF || sel !== 4'b0100 || TDO_IR !== 1'b0 || TDO_EN !== 1'b0) begin
            errors++;
            $display("FAIL midrst_tlr: state=%h sel=%b tdo_ir=%b tdo_en=%b, required F 0100 0 0",
                     Tap_State, sel, TDO_IR, TDO_EN);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (Tap_State !== 4'hC || sel !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_after: state=%h sel=%b, required C 0100", Tap_State, sel);
        end
    endtask

    initial begin
        test_reset();
        test_fsm_walk();
        test_ir_extest();
        test_tms_reset_pause_ir();
        test_bypass_undefined();
        test_tms_reset_shift_dr();
        test_sample_idcode();
        test_dr_scan();
        test_rst_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
